// File: rtl/uart_tx_fifo.sv
// UART transmitter with an internal baud divider and a small write FIFO.
// The frame format (data width, parity and stop bits) is set by parameters.
// Words queued back-to-back are sent with no idle gap between frames.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk50,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 write_en,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 full,
  output logic                 overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]  STOP_LAST = 4'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
    $error("uart_tx_fifo: CLKS_PER_BIT must be 2..65535");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_fifo: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP
  } state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 full_q, empty_q, overflow_q;
  logic                 wr_ok, pop;
  logic [DATA_BITS-1:0] head;
  logic                 head_par;

  state_t               state_q;
  logic                 tx_q;
  logic [15:0]          baud_q;
  logic [3:0]           bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_q;
  logic                 baud_last;

  assign head      = mem[rd_ptr_q];
  assign head_par  = (PARITY == 1) ? ~(^head) : (^head);
  assign baud_last = (baud_q == BAUD_LAST);
  assign wr_ok     = write_en && !full_q;

  // Pop the head when idle, or at the last stop-bit boundary to chain frames.
  always_comb begin
    pop = 1'b0;
    if (!empty_q) begin
      if (state_q == ST_IDLE) begin
        pop = 1'b1;
      end else if (state_q == ST_STOP && baud_last && bit_q == STOP_LAST) begin
        pop = 1'b1;
      end
    end
  end

  // Next-state for FIFO pointers and occupancy count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + PW'(1);
    case ({wr_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage; contents need no reset since the count gates every read.
  always_ff @(posedge clk50) begin
    if (wr_ok) mem[wr_ptr_q] <= din;
  end

  // FIFO pointers, count, registered flags and the overflow pulse.
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= (count_d == CW'(FIFO_DEPTH));
      empty_q    <= (count_d == '0);
      overflow_q <= write_en && full_q;
    end
  end

  // Frame engine: walks start, data, parity and stop bits with a registered tx.
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tx_q    <= 1'b1;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q <= head;
            par_q   <= head_par;
            tx_q    <= 1'b0;
            baud_q  <= '0;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          if (baud_last) begin
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= ST_DATA;
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        ST_DATA: begin
          if (baud_last) begin
            baud_q <= '0;
            if (bit_q == DATA_LAST) begin
              bit_q <= '0;
              if (PARITY != 0) begin
                tx_q    <= par_q;
                state_q <= ST_PARITY;
              end else begin
                tx_q    <= 1'b1;
                state_q <= ST_STOP;
              end
            end else begin
              bit_q   <= bit_q + 4'd1;
              shift_q <= shift_q >> 1;
              tx_q    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        ST_PARITY: begin
          if (baud_last) begin
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
            state_q <= ST_STOP;
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        ST_STOP: begin
          if (baud_last) begin
            baud_q <= '0;
            if (bit_q == STOP_LAST) begin
              bit_q <= '0;
              if (pop) begin
                shift_q <= head;
                par_q   <= head_par;
                tx_q    <= 1'b0;
                state_q <= ST_START;
              end else begin
                tx_q    <= 1'b1;
                state_q <= ST_IDLE;
              end
            end else begin
              bit_q <= bit_q + 4'd1;
            end
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          tx_q    <= 1'b1;
          baud_q  <= '0;
          bit_q   <= '0;
        end
      endcase
    end
  end

  assign tx       = tx_q;
  assign tx_busy  = (state_q != ST_IDLE) || !empty_q;
  assign full     = full_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed testbench for uart_tx_fifo: four instances cover 8N1, even parity,
// odd parity and 7-data/2-stop framing with hand-written expected frames.
module tb_uart_tx_fifo;

  logic       clk50 = 1'b0;
  logic       rst_n;
  logic [3:0] we_v   = '0;
  logic [3:0] tx_v, busy_v, full_v, ovf_v;
  logic [7:0] din0 = '0, din1 = '0, din2 = '0;
  logic [6:0] din3 = '0;

  int checks = 0;
  int errors = 0;

  // Free-running 100 MHz-style clock; only the cycle count matters here.
  always #5 clk50 = ~clk50;

  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
    u_8n1  (.clk50(clk50), .rst_n(rst_n), .din(din0), .write_en(we_v[0]),
            .tx(tx_v[0]), .tx_busy(busy_v[0]), .full(full_v[0]), .overflow(ovf_v[0]));
  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4))
    u_even (.clk50(clk50), .rst_n(rst_n), .din(din1), .write_en(we_v[1]),
            .tx(tx_v[1]), .tx_busy(busy_v[1]), .full(full_v[1]), .overflow(ovf_v[1]));
  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4))
    u_odd  (.clk50(clk50), .rst_n(rst_n), .din(din2), .write_en(we_v[2]),
            .tx(tx_v[2]), .tx_busy(busy_v[2]), .full(full_v[2]), .overflow(ovf_v[2]));
  uart_tx_fifo #(.CLKS_PER_BIT(8), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4))
    u_7n2  (.clk50(clk50), .rst_n(rst_n), .din(din3), .write_en(we_v[3]),
            .tx(tx_v[3]), .tx_busy(busy_v[3]), .full(full_v[3]), .overflow(ovf_v[3]));

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One-cycle write strobe on instance inst; returns 1 time unit after the accepting edge.
  task automatic applyStimulus(input int inst, input logic [7:0] word);
    case (inst)
      0:       din0 = word;
      1:       din1 = word;
      2:       din2 = word;
      default: din3 = word[6:0];
    endcase
    we_v[inst] = 1'b1;
    @(posedge clk50);
    #1;
    we_v = '0;
  endtask

  // Samples a whole frame (bit 0 = start bit) at falling edges, one check per bit,
  // and checks that tx_busy never dropped during the frame.
  task automatic expectFrame(input int inst, input logic [15:0] frame, input int nbits,
                             input int cpb, input string tag);
    logic [31:0] obs;
    int gaps;
    gaps = 0;
    for (int b = 0; b < nbits; b++) begin
      obs = '0;
      for (int c = 0; c < cpb; c++) begin
        @(negedge clk50);
        obs[c] = tx_v[inst];
        if (!busy_v[inst]) gaps++;
      end
      checkOutput($sformatf("%s bit%0d", tag, b), obs,
                  frame[b] ? ((32'd1 << cpb) - 32'd1) : 32'd0);
    end
    checkOutput({tag, " busy_gap"}, 32'(gaps), 32'd0);
  endtask

  // Hard stop in case the sequence below ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main directed sequence.
  initial begin
    int bad;
    rst_n = 1'b0;
    repeat (3) @(negedge clk50);
    checkOutput("rst tx",   32'(tx_v),   32'hF);
    checkOutput("rst busy", 32'(busy_v), 32'h0);
    checkOutput("rst full", 32'(full_v), 32'h0);
    checkOutput("rst ovf",  32'(ovf_v),  32'h0);
    rst_n = 1'b1;
    @(negedge clk50);

    // 8N1 0xA5: one idle cycle after the write, then 0,1,0,1,0,0,1,0,1,1.
    applyStimulus(0, 8'hA5);
    @(negedge clk50);
    checkOutput("a5 latency tx", 32'(tx_v[0]), 32'd1);
    checkOutput("a5 busy on",    32'(busy_v[0]), 32'd1);
    expectFrame(0, 16'({1'b1, 8'hA5, 1'b0}), 10, 4, "a5");
    @(negedge clk50);
    checkOutput("a5 busy off", 32'(busy_v[0]), 32'd0);
    checkOutput("a5 idle tx",  32'(tx_v[0]),   32'd1);

    // Even parity 0x07 (three ones) -> parity 1.
    applyStimulus(1, 8'h07);
    @(negedge clk50);
    expectFrame(1, 16'({1'b1, 1'b1, 8'h07, 1'b0}), 11, 4, "even07");
    @(negedge clk50);
    checkOutput("even07 busy off", 32'(busy_v[1]), 32'd0);

    // Odd parity 0x03 (two ones) -> 1; odd parity 0x07 (three ones) -> 0.
    applyStimulus(2, 8'h03);
    @(negedge clk50);
    expectFrame(2, 16'({1'b1, 1'b1, 8'h03, 1'b0}), 11, 4, "odd03");
    @(negedge clk50);
    applyStimulus(2, 8'h07);
    @(negedge clk50);
    expectFrame(2, 16'({1'b1, 1'b0, 8'h07, 1'b0}), 11, 4, "odd07");
    @(negedge clk50);
    checkOutput("odd07 busy off", 32'(busy_v[2]), 32'd0);

    // Three consecutive writes -> three gap-free frames in order.
    fork
      begin
        applyStimulus(0, 8'h11);
        applyStimulus(0, 8'h22);
        applyStimulus(0, 8'h33);
      end
      begin
        @(negedge clk50);
        expectFrame(0, 16'({1'b1, 8'h11, 1'b0}), 10, 4, "b2b11");
        expectFrame(0, 16'({1'b1, 8'h22, 1'b0}), 10, 4, "b2b22");
        expectFrame(0, 16'({1'b1, 8'h33, 1'b0}), 10, 4, "b2b33");
      end
    join
    @(negedge clk50);
    checkOutput("b2b busy off", 32'(busy_v[0]), 32'd0);

    // Six writes at edges E0..E5: first pop at E1, full after E4, 0x06 dropped.
    applyStimulus(0, 8'h01);
    applyStimulus(0, 8'h02);
    applyStimulus(0, 8'h03);
    applyStimulus(0, 8'h04);
    checkOutput("ovf full after E3", 32'(full_v[0]), 32'd0);
    applyStimulus(0, 8'h05);
    checkOutput("ovf full after E4", 32'(full_v[0]), 32'd1);
    checkOutput("ovf low after E4",  32'(ovf_v[0]),  32'd0);
    applyStimulus(0, 8'h06);
    checkOutput("ovf pulse",        32'(ovf_v[0]),  32'd1);
    checkOutput("ovf full held",    32'(full_v[0]), 32'd1);
    @(posedge clk50);
    #1;
    checkOutput("ovf pulse ends",   32'(ovf_v[0]),  32'd0);
    repeat (35) @(negedge clk50);
    expectFrame(0, 16'({1'b1, 8'h02, 1'b0}), 10, 4, "ovf02");
    expectFrame(0, 16'({1'b1, 8'h03, 1'b0}), 10, 4, "ovf03");
    expectFrame(0, 16'({1'b1, 8'h04, 1'b0}), 10, 4, "ovf04");
    expectFrame(0, 16'({1'b1, 8'h05, 1'b0}), 10, 4, "ovf05");
    @(negedge clk50);
    checkOutput("ovf only five busy", 32'(busy_v[0]), 32'd0);
    checkOutput("ovf only five tx",   32'(tx_v[0]),   32'd1);

    // 7 data bits of 0x55, then 16 cycles of stop level.
    applyStimulus(3, 8'h55);
    @(negedge clk50);
    expectFrame(3, 16'({2'b11, 7'h55, 1'b0}), 10, 8, "d7s2");
    @(negedge clk50);
    checkOutput("d7s2 busy off", 32'(busy_v[3]), 32'd0);

    // Reset mid-DATA (bit 1 of 0xF0 is low) with two words still queued.
    applyStimulus(0, 8'hF0);
    applyStimulus(0, 8'h0F);
    applyStimulus(0, 8'h3C);
    repeat (8) @(negedge clk50);
    checkOutput("rst mid tx low", 32'(tx_v[0]), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst mid tx",   32'(tx_v[0]),   32'd1);
    checkOutput("rst mid busy", 32'(busy_v[0]), 32'd0);
    checkOutput("rst mid full", 32'(full_v[0]), 32'd0);
    repeat (2) @(negedge clk50);
    rst_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk50);
      if (!tx_v[0] || busy_v[0]) bad++;
    end
    checkOutput("rst idle after release", 32'(bad), 32'd0);
    applyStimulus(0, 8'h5A);
    @(negedge clk50);
    expectFrame(0, 16'({1'b1, 8'h5A, 1'b0}), 10, 4, "post5a");
    @(negedge clk50);
    checkOutput("post5a busy off", 32'(busy_v[0]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
